bcd_display_ctrl: RTL and testbench
===================================

Name: bcd_display_ctrl

Overview:
Sequencing controller that converts an unsigned binary value into decimal digits and drives a bank of active-low seven-segment displays (HEX0..HEXn on the DE10-Lite). Conversion is sequential shift-add-3 (double-dabble), one bit per clock, with a start/busy/done handshake toward the requesting logic. It holds the last valid display pattern while converting, blanks leading zeros on request, and shows dashes on overflow. Decimal digit to segment mapping uses the team's standard 0-9 active-low patterns, {a..g} = [6:0].

Parameters:
WIDTH, 20, bit width of BinIn; legal range 4..20
DIGITS, 6, number of decimal digits and displays driven; legal range 1..6

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
Start  input  1  request conversion of BinIn; sampled only in IDLE
BinIn  input  WIDTH  unsigned value to display; captured on accepted Start
LzBlank  input  1  blank leading zeros when 1; captured on accepted Start
Busy  output  1  high while a conversion is in progress
Done  output  1  one-cycle pulse when new digits and segments are valid
Overflow  output  1  registered; 1 if the last captured value exceeds 10^DIGITS-1
BcdOut  output  4*DIGITS  registered BCD digits, digit 0 = least significant in [3:0]
HexSeg  output  7*DIGITS  active-low segments, display k in [7k+6:7k]

Behaviour:
- Reset (synchronous, active-high, takes priority over all inputs): state=IDLE, Busy=0, Done=0, Overflow=0, BcdOut=0, all HexSeg bits=1 (all displays dark). Reset during CONVERT aborts the conversion with no Done pulse.
- States: IDLE, CONVERT, FINISH.
- IDLE: Start=1 captures BinIn into the shift register, clears the BCD accumulator, captures LzBlank, loads bit counter = WIDTH, and moves to CONVERT. Busy rises the next cycle.
- CONVERT: each cycle, every BCD nibble >= 5 gets +3, then the {BCD, binary} register shifts left by 1. Counter decrements. After WIDTH cycles go to FINISH. Start is ignored while Busy=1. Changes to BinIn and LzBlank are ignored.
- FINISH (one cycle): register BcdOut, Overflow, and the display pattern. Assert Done=1 and Busy=0. Return to IDLE.
- Latency: Start accepted in cycle 0. Busy=1 in cycles 1..WIDTH. Done=1 in cycle WIDTH+1. Outputs update in that cycle.
- A new Start is accepted in the cycle after Done, the earliest IDLE cycle. Back-to-back operation gives a throughput of one conversion per WIDTH+2 cycles.
- Accumulator width is 4*DIGITS+4 bits. The extra nibble captures an overflow digit.
- Overflow: set when any accumulator bit above 4*DIGITS is nonzero at FINISH. When set:
  - every display shows dash (segment g only, 7'b0111111);
  - BcdOut holds the low DIGITS digits unchanged.
- Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any non-BCD nibble maps to 1111111. This is unreachable in correct operation.
- Leading-zero blanking (LzBlank=1, no overflow): blank (1111111) each display above the most significant nonzero digit. Display 0 is always shown, so a value of 0 shows a single "0".
- HexSeg and BcdOut are registered and hold their previous values during CONVERT, so the display does not flicker.
- Done is high for exactly one cycle per accepted Start. Busy and Done are never high together.

Test Plan:
- Reset then idle, WIDTH=20, DIGITS=6 -> HexSeg all 1s, BcdOut=0, Busy=0, Done=0, Overflow=0.
- Start with BinIn=123456, LzBlank=0 -> Busy cycles 1..20, Done at cycle 21, BcdOut=24'h123456, HEX0=0000010 (6) and HEX5=1111001 (1).
- BinIn=0 with LzBlank=1 -> HEX0=1000000, HEX1..HEX5=1111111. BinIn=907 with LzBlank=1 -> HEX2..HEX0 show 9,0,7 and HEX3..HEX5 are blank.
- BinIn=999999 -> no overflow, all displays show 9 (0010000). Then BinIn=1000000 -> Overflow=1, all displays 0111111.
- During a conversion of 42, drive Start=1 with BinIn=77 for cycles 3..10 -> result is 42, exactly one Done pulse, HexSeg keeps the prior value until Done.
- Assert Reset at cycle 10 of a conversion -> Busy=0 next cycle, no Done, displays dark. Then Start with 5 -> Done after 21 cycles, HEX0=0010010.

Source files
------------

// File: rtl/bcd_display_ctrl_if.sv
// Request/result bundle between a requester and the BCD display controller.
// The requester drives start/bin_in/lz_blank; the controller returns status, digits and segments.
interface bcd_display_ctrl_if #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  lz_blank;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [7*DIGITS-1:0]   hex_seg;

  modport master (
    output start, bin_in, lz_blank,
    input  busy, done, overflow, bcd_out, hex_seg
  );

  modport slave (
    input  start, bin_in, lz_blank,
    output busy, done, overflow, bcd_out, hex_seg
  );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Sequential double-dabble binary-to-BCD converter driving active-low seven-segment displays,
// with leading-zero blanking, dash display on overflow and a start/busy/done handshake.
module bcd_display_ctrl #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  bcd_display_ctrl_if.slave bus
);

  localparam int ACC_W = 4*DIGITS + 4;
  localparam int BCD_W = 4*DIGITS;
  localparam int SEG_W = 7*DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;
  localparam logic [6:0]       SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_FINISH  = 2'd2
  } state_e;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [ACC_W-1:0] add3_all(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] res;
    res = acc;
    for (int k = 0; k < DIGITS + 1; k++) begin
      if (res[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = res[4*k +: 4] + 4'd3;
      end else begin
        res[4*k +: 4] = res[4*k +: 4];
      end
    end
    return res;
  endfunction

  // Display 0 is never blanked so that a zero value still shows a single "0".
  function automatic logic [SEG_W-1:0] render(input logic [BCD_W-1:0] bcd,
                                              input logic lz, input logic ovf);
    logic [SEG_W-1:0] seg;
    logic             leading;
    seg     = '1;
    leading = lz;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (ovf) begin
        seg[7*k +: 7] = SEG_DASH;
      end else if (leading && (k != 0) && (bcd[4*k +: 4] == 4'd0)) begin
        seg[7*k +: 7] = SEG_BLANK;
      end else begin
        seg[7*k +: 7] = seg_of(bcd[4*k +: 4]);
        leading       = 1'b0;
      end
    end
    return seg;
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lz_q, lz_d;
  logic               lost_q, lost_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [SEG_W-1:0]   seg_q, seg_d;

  logic [ACC_W-1:0]   acc_adj_s;
  logic [ACC_W-1:0]   acc_shift_s;
  logic               ovf_fin_s;

  // One double-dabble step; lost_q remembers any carry pushed out of the spare nibble.
  always_comb begin
    acc_adj_s   = add3_all(acc_q);
    acc_shift_s = {acc_adj_s[ACC_W-2:0], bin_q[WIDTH-1]};
    ovf_fin_s   = lost_q | acc_adj_s[ACC_W-1] | (|acc_shift_s[ACC_W-1:BCD_W]);
  end

  // Next-state and next-output logic for the IDLE/CONVERT/FINISH sequencer.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    lz_d    = lz_q;
    lost_d  = lost_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    seg_d   = seg_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_CONVERT;
          bin_d   = bus.bin_in;
          acc_d   = '0;
          lz_d    = bus.lz_blank;
          cnt_d   = CNT_LOAD;
          lost_d  = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        acc_d  = acc_shift_s;
        bin_d  = {bin_q[WIDTH-2:0], 1'b0};
        lost_d = lost_q | acc_adj_s[ACC_W-1];
        cnt_d  = cnt_q - CNT_ONE;
        // Results are registered on the last shift so they appear together with Done.
        if (cnt_q == CNT_ONE) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          ovf_d   = ovf_fin_s;
          bcd_d   = acc_shift_s[BCD_W-1:0];
          seg_d   = render(acc_shift_s[BCD_W-1:0], lz_q, ovf_fin_s);
        end else begin
          busy_d  = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      lz_q    <= 1'b0;
      lost_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      seg_q   <= '1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      lz_q    <= lz_d;
      lost_q  <= lost_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.hex_seg  = seg_q;

  bcd_display_ctrl_chk u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .busy_i  (busy_q),
    .done_i  (done_q)
  );

endmodule

// Handshake invariants for the controller outputs.
module bcd_display_ctrl_chk (
  input logic clk_i,
  input logic reset_i,
  input logic busy_i,
  input logic done_i
);

  a_busy_done_excl: assert property (@(posedge clk_i) disable iff (reset_i)
    !(busy_i && done_i));

  a_done_single: assert property (@(posedge clk_i) disable iff (reset_i)
    done_i |=> !done_i);

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed, table-driven bench for bcd_display_ctrl at WIDTH=20, DIGITS=6.
module tb_bcd_display_ctrl;

  localparam int WIDTH  = 20;
  localparam int DIGITS = 6;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  typedef struct {
    logic [19:0] bin;
    logic        lz;
    logic [23:0] bcd;
    logic [41:0] seg;
    logic        ovf;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [41:0] prev_seg;
  logic [23:0] prev_bcd;
  logic        prev_ovf;

  always #5 clk = ~clk;

  bcd_display_ctrl_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bcd_display_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts a conversion and follows it to Done; with glitch set, Start/BinIn=77 are driven in cycles 3..10.
  task automatic run_conv(input logic [19:0] bin, input logic lz, input bit glitch,
                          output int done_cyc, output int busy_cnt, output bit hold_ok);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.bin_in   = bin;
    bus.lz_blank = lz;
    done_cyc = -1;
    busy_cnt = 0;
    hold_ok  = 1'b1;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (glitch && c >= 3 && c <= 10) begin
        bus.start  = 1'b1;
        bus.bin_in = 20'd77;
      end else begin
        bus.start  = 1'b0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.done) hold_ok = 1'b0;
      if (bus.done) done_cyc = c;
      else if (bus.hex_seg !== prev_seg || bus.bcd_out !== prev_bcd || bus.overflow !== prev_ovf)
        hold_ok = 1'b0;
    end
  endtask

  task automatic conv_and_check(input string name, input vec_t v, input bit glitch);
    int dc;
    int bc;
    bit ho;
    run_conv(v.bin, v.lz, glitch, dc, bc, ho);
    check({name, ".done_cycle"}, 64'(dc), 64'(WIDTH + 1));
    check({name, ".busy_cycles"}, 64'(bc), 64'(WIDTH));
    check({name, ".hold"}, 64'(ho), 64'd1);
    check({name, ".bcd"}, 64'(bus.bcd_out), 64'(v.bcd));
    check({name, ".seg"}, 64'(bus.hex_seg), 64'(v.seg));
    check({name, ".ovf"}, 64'(bus.overflow), 64'(v.ovf));
    prev_seg = v.seg;
    prev_bcd = v.bcd;
    prev_ovf = v.ovf;
  endtask

  initial begin
    vec_t vecs[10];
    vec_t v;
    int   dones;

    vecs[0] = '{20'd123456,  1'b0, 24'h123456, {S1, S2, S3, S4, S5, S6}, 1'b0};
    vecs[1] = '{20'd0,       1'b1, 24'h000000, {BL, BL, BL, BL, BL, S0}, 1'b0};
    vecs[2] = '{20'd907,     1'b1, 24'h000907, {BL, BL, BL, S9, S0, S7}, 1'b0};
    vecs[3] = '{20'd999999,  1'b0, 24'h999999, {S9, S9, S9, S9, S9, S9}, 1'b0};
    vecs[4] = '{20'd1000000, 1'b0, 24'h000000, {DS, DS, DS, DS, DS, DS}, 1'b1};
    vecs[5] = '{20'd907,     1'b0, 24'h000907, {S0, S0, S0, S9, S0, S7}, 1'b0};
    vecs[6] = '{20'd1048575, 1'b1, 24'h048575, {DS, DS, DS, DS, DS, DS}, 1'b1};
    vecs[7] = '{20'd100000,  1'b1, 24'h100000, {S1, S0, S0, S0, S0, S0}, 1'b0};
    vecs[8] = '{20'd10,      1'b1, 24'h000010, {BL, BL, BL, BL, S1, S0}, 1'b0};
    vecs[9] = '{20'd0,       1'b0, 24'h000000, {S0, S0, S0, S0, S0, S0}, 1'b0};

    bus.start    = 1'b0;
    bus.bin_in   = '0;
    bus.lz_blank = 1'b0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.done", 64'(bus.done), 64'd0);
    check("reset.ovf",  64'(bus.overflow), 64'd0);
    check("reset.bcd",  64'(bus.bcd_out), 64'd0);
    check("reset.seg",  64'(bus.hex_seg), {22'd0, 42'h3FF_FFFF_FFFF});
    prev_seg = '1;
    prev_bcd = '0;
    prev_ovf = 1'b0;

    // Back-to-back: each new Start lands in the first IDLE cycle after Done.
    for (int i = 0; i < 10; i++) begin
      conv_and_check($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    v = '{20'd42, 1'b0, 24'h000042, {S0, S0, S0, S0, S4, S2}, 1'b0};
    conv_and_check("ignore_start", v, 1'b1);
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("ignore_start.no_extra", 64'(dones), 64'd0);

    // Reset asserted in cycle 10 of a conversion aborts it.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.bin_in   = 20'd123456;
    bus.lz_blank = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.done", 64'(bus.done), 64'd0);
    check("abort.seg",  64'(bus.hex_seg), {22'd0, 42'h3FF_FFFF_FFFF});
    check("abort.bcd",  64'(bus.bcd_out), 64'd0);
    check("abort.ovf",  64'(bus.overflow), 64'd0);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort.no_done", 64'(dones), 64'd0);
    prev_seg = '1;
    prev_bcd = '0;
    prev_ovf = 1'b0;
    v = '{20'd5, 1'b1, 24'h000005, {BL, BL, BL, BL, BL, S5}, 1'b0};
    conv_and_check("after_abort", v, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
